// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop input synchronizer, mid-bit sampling FSM,
// holding register for the last correctly framed byte plus a one-cycle strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_in,
  output logic       data_received
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          r_state;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;

  // Two-flop synchronizer on the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame recovery FSM with registered byte output and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      data_in       <= '0;
      data_received <= 1'b0;
    end else begin
      data_received <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              data_in       <= r_shift;
              data_received <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_state <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          r_cnt <= '0;
          if (r_rx_s) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=8, 20 ns clock.
module tb_uart_rx;

  localparam int unsigned CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_in;
  logic       data_received;

  int checks;
  int failures;
  int pulses;
  int p0;
  logic [7:0] got[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_in       (data_in),
    .data_received (data_received)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count strobe cycles and log the byte presented with each one.
  always @(negedge clk) begin
    if (data_received === 1'b1) begin
      pulses++;
      got.push_back(data_in);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pulses   = 0;
    rx       = 1'b1;
    rst_n    = 1'b0;

    // Reset values
    wait_clks(3);
    check("rst_data_in", 32'(data_in), 32'h00);
    check("rst_data_received", 32'(data_received), 32'h0);
    rst_n = 1'b1;
    wait_clks(20);
    check("idle_no_pulse", 32'(pulses), 32'd0);

    // Single frame 0x55
    p0 = pulses;
    send_frame(8'h55, 1'b1);
    wait_clks(4);
    check("f55_pulses", 32'(pulses - p0), 32'd1);
    check("f55_data", 32'(data_in), 32'h55);
    wait_clks(29);
    check("f55_hold_data", 32'(data_in), 32'h55);
    check("f55_hold_pulses", 32'(pulses - p0), 32'd1);

    // Second frame 0x77
    p0 = pulses;
    send_frame(8'h77, 1'b1);
    wait_clks(4);
    check("f77_pulses", 32'(pulses - p0), 32'd1);
    check("f77_data", 32'(data_in), 32'h77);

    // Back-to-back frames, zero idle gap
    wait_clks(10);
    p0 = pulses;
    send_frame(8'h77, 1'b1);
    send_frame(8'hE1, 1'b1);
    wait_clks(4);
    check("b2b_pulses", 32'(pulses - p0), 32'd2);
    check("b2b_first", 32'(got[got.size()-2]), 32'h77);
    check("b2b_second", 32'(got[got.size()-1]), 32'hE1);

    // Start glitch: two clocks low
    wait_clks(10);
    p0 = pulses;
    rx = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(20);
    check("glitch_no_pulse", 32'(pulses - p0), 32'd0);
    check("glitch_data_kept", 32'(data_in), 32'hE1);
    send_frame(8'hA3, 1'b1);
    wait_clks(4);
    check("fA3_pulses", 32'(pulses - p0), 32'd1);
    check("fA3_data", 32'(data_in), 32'hA3);

    // Framing error: stop bit low, line held low three more bit times
    wait_clks(10);
    p0 = pulses;
    send_frame(8'h12, 1'b0);
    wait_clks(3 * CPB);
    rx = 1'b1;
    wait_clks(16);
    check("ferr_no_pulse", 32'(pulses - p0), 32'd0);
    check("ferr_data_kept", 32'(data_in), 32'hA3);
    send_frame(8'h34, 1'b1);
    wait_clks(4);
    check("f34_pulses", 32'(pulses - p0), 32'd1);
    check("f34_data", 32'(data_in), 32'h34);

    // Mid-frame reset during data bit 4 of 0xF5 (bits 4..7 and stop are high)
    wait_clks(10);
    p0 = pulses;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'hF5 >> i) & 8'h01) != 8'h00;
      wait_clks(CPB);
    end
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_in", 32'(data_in), 32'h00);
    check("mid_rst_data_received", 32'(data_received), 32'h0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(40);
    check("mid_rst_no_pulse", 32'(pulses - p0), 32'd0);
    check("mid_rst_data_held", 32'(data_in), 32'h00);
    send_frame(8'hC6, 1'b1);
    wait_clks(4);
    check("fC6_pulses", 32'(pulses - p0), 32'd1);
    check("fC6_data", 32'(data_in), 32'hC6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
